// File: rtl/top_entity.sv
// top_entity: 5-entry signed shift queue, newest entry in mem0, oldest at mem[cursor-1]
// Ports: clk, rst (sync, active-high), en (clock enable), push/pop requests, data in;
// registered push_valid/pop_valid/out result flags, mem0..mem4 storage view, cursor entry count.
module top_entity #(
  parameter int DEPTH = 5,
  parameter int WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    push,
  input  logic                    pop,
  input  logic signed [WIDTH-1:0] data,
  output logic                    push_valid,
  output logic                    pop_valid,
  output logic signed [WIDTH-1:0] out,
  output logic signed [WIDTH-1:0] mem0,
  output logic signed [WIDTH-1:0] mem1,
  output logic signed [WIDTH-1:0] mem2,
  output logic signed [WIDTH-1:0] mem3,
  output logic signed [WIDTH-1:0] mem4,
  output logic signed [WIDTH-1:0] cursor
);
  localparam int CW = $clog2(DEPTH + 1);
  logic signed [WIDTH-1:0] mem [DEPTH];
  logic signed [WIDTH-1:0] mem_p [DEPTH];
  logic signed [WIDTH-1:0] mem_n [DEPTH];
  logic signed [WIDTH-1:0] out_n;
  logic [CW-1:0] cnt, cnt_p, cnt_n, oldest;
  logic do_pop, do_push;
  always_comb begin
    oldest  = cnt - CW'(1);
    do_pop  = pop && cnt != '0;
    cnt_p   = cnt - CW'(do_pop);
    do_push = push && cnt_p < CW'(DEPTH);
    cnt_n   = cnt_p + CW'(do_push);
    out_n   = do_pop ? mem[oldest] : '0;
    for (int i = 0; i < DEPTH; i++)
      mem_p[i] = (do_pop && CW'(i) == oldest) ? '0 : mem[i];
    // A push shifts everything one slot toward the tail; the tail slot is
    // always empty here because the post-pop count is below DEPTH.
    mem_n[0] = do_push ? data : mem_p[0];
    for (int i = 1; i < DEPTH; i++)
      mem_n[i] = do_push ? mem_p[i-1] : mem_p[i];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      cnt        <= '0;
      out        <= '0;
      push_valid <= 1'b0;
      pop_valid  <= 1'b0;
    end else if (en) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= mem_n[i];
      cnt        <= cnt_n;
      out        <= out_n;
      push_valid <= do_push;
      pop_valid  <= do_pop;
    end
  end
  assign mem0   = mem[0];
  assign mem1   = mem[1];
  assign mem2   = mem[2];
  assign mem3   = mem[3];
  assign mem4   = mem[4];
  assign cursor = {{(WIDTH-CW){1'b0}}, cnt};
endmodule

// File: tb/tb_top_entity.sv
// tb_top_entity: directed and random checks of top_entity against a queue-based reference model
module tb_top_entity;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, push = 1'b0, pop = 1'b0;
  logic signed [63:0] data = '0;
  logic push_valid, pop_valid;
  logic signed [63:0] out, mem0, mem1, mem2, mem3, mem4, cursor;
  int errors = 0, checks = 0;
  longint q[$];
  longint m_out = 0;
  logic m_pv = 1'b0, m_ppv = 1'b0;

  top_entity #(.DEPTH(5), .WIDTH(64)) dut (
    .clk(clk), .rst(rst), .en(en), .push(push), .pop(pop), .data(data),
    .push_valid(push_valid), .pop_valid(pop_valid), .out(out),
    .mem0(mem0), .mem1(mem1), .mem2(mem2), .mem3(mem3), .mem4(mem4),
    .cursor(cursor)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint slot(input int i);
    return i < q.size() ? q[i] : 64'sd0;
  endfunction

  task automatic step(input logic r, input logic e, input logic pu, input logic po, input logic signed [63:0] d);
    @(negedge clk);
    rst = r; en = e; push = pu; pop = po; data = d;
    @(posedge clk);
    #1;
    if (r) begin
      q.delete(); m_out = 0; m_pv = 1'b0; m_ppv = 1'b0;
    end else if (e) begin
      m_out = 0; m_pv = 1'b0; m_ppv = 1'b0;
      if (po && q.size() > 0) begin m_out = q.pop_back(); m_ppv = 1'b1; end
      if (pu && q.size() < 5) begin q.push_front(d); m_pv = 1'b1; end
    end
    check("push_valid", 64'(push_valid), 64'(m_pv));
    check("pop_valid", 64'(pop_valid), 64'(m_ppv));
    check("out", out, m_out);
    check("cursor", cursor, 64'(q.size()));
    check("mem0", mem0, slot(0));
    check("mem1", mem1, slot(1));
    check("mem2", mem2, slot(2));
    check("mem3", mem3, slot(3));
    check("mem4", mem4, slot(4));
  endtask

  initial begin
    step(1, 0, 0, 0, 0);
    check("reset_cursor", cursor, 0);
    step(0, 1, 1, 0, 1);
    step(0, 1, 1, 0, 2);
    step(0, 1, 1, 0, 3);
    check("r28_mem0", mem0, 3);
    check("r28_mem2", mem2, 1);
    check("r28_cursor", cursor, 3);
    step(0, 1, 0, 1, 0);
    check("r29_out", out, 1);
    step(0, 1, 1, 1, 4);
    step(0, 1, 1, 1, 5);
    check("r29_out5", out, 3);
    check("r29_mem0", mem0, 5);
    step(0, 1, 0, 1, 0);
    check("r30_out4", out, 4);
    step(0, 1, 1, 1, 6);
    step(0, 1, 0, 1, 0);
    check("r30_cursor0", cursor, 0);
    step(0, 1, 1, 1, 7);
    check("r30_empty_pp_out", out, 0);
    check("r30_empty_pp_pv", 64'(push_valid), 1);
    step(0, 1, 0, 1, 0);
    step(0, 1, 0, 1, 0);
    step(0, 1, 0, 1, 0);
    check("r30_idle_popv", 64'(pop_valid), 0);
    step(1, 1, 0, 0, 0);
    for (int i = 10; i <= 14; i++) step(0, 1, 1, 0, i);
    step(0, 1, 1, 0, 15);
    check("r31_full_pv", 64'(push_valid), 0);
    check("r31_full_mem4", mem4, 10);
    step(0, 1, 1, 1, 15);
    check("r31_pp_out", out, 10);
    check("r31_pp_mem0", mem0, 15);
    check("r31_pp_cursor", cursor, 5);
    step(0, 0, 1, 1, 99);
    check("r32_hold_out", out, 10);
    step(1, 1, 1, 1, 42);
    check("r32_rst_mem0", mem0, 0);
    step(0, 1, 1, 0, -5);
    check("r27_cursor1", cursor, 1);
    repeat (400)
      step($urandom_range(0, 39) == 0, $urandom_range(0, 4) != 0,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $signed({$urandom, $urandom}));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
